// File: rtl/reg_file_sb.sv
// reg_file_sb: integer register file with per-register busy scoreboard.
// Two combinational read ports, one synchronous write port, a post-reset
// init sweep, claim/clear busy tracking and an optional write-to-read bypass.
module reg_file_sb #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int BYPASS    = 1,
  parameter int INIT_MODE = 1
) (
  input  logic              clock,
  input  logic              reset,
  output logic              ready,
  input  logic [ADDR_W-1:0] read_reg_num1,
  output logic [DATA_W-1:0] read_data1,
  output logic              read_busy1,
  input  logic [ADDR_W-1:0] read_reg_num2,
  output logic [DATA_W-1:0] read_data2,
  output logic              read_busy2,
  input  logic              regwrite,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  input  logic              claim_en,
  input  logic [ADDR_W-1:0] claim_reg,
  output logic [ADDR_W:0]   busy_count
);

  localparam int N = 2 ** ADDR_W;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] init_ptr;
  logic [DATA_W-1:0] init_val;
  logic [DATA_W-1:0] mem [N];
  logic [N-1:0]      busy;
  logic              run;
  logic              write_ok;
  logic              claim_ok;
  logic              cnt_inc;
  logic              cnt_dec;

  assign run      = (state == ST_RUN);
  assign ready    = run;
  assign write_ok = run && regwrite && (write_reg != '0);
  assign claim_ok = run && claim_en && (claim_reg != '0);
  assign init_val = (INIT_MODE != 0) ? DATA_W'(init_ptr) : '0;

  // busy_count moves only when a bit actually flips; a same-register
  // claim+write leaves the bit set, so the write never decrements then
  assign cnt_inc  = claim_ok && !busy[claim_reg];
  assign cnt_dec  = write_ok && busy[write_reg] &&
                    !(claim_ok && (claim_reg == write_reg));

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= ST_INIT;
    else        state <= state_nxt;
  end

  // Next-state: leave INIT on the edge that writes the last entry
  always_comb begin
    state_nxt = state;
    if (state == ST_INIT && (&init_ptr)) state_nxt = ST_RUN;
  end

  // Init sweep pointer
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                init_ptr <= '0;
    else if (state == ST_INIT) init_ptr <= init_ptr + 1'b1;
  end

  // Storage: sweep writes during INIT, writeback port during RUN (no reset)
  always_ff @(posedge clock) begin
    if (state == ST_INIT) mem[init_ptr]  <= init_val;
    else if (write_ok)    mem[write_reg] <= write_data;
  end

  // Busy bits: writeback clears, claim sets; claim is last so it wins
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy <= '0;
    end else begin
      if (write_ok) busy[write_reg] <= 1'b0;
      if (claim_ok) busy[claim_reg] <= 1'b1;
    end
  end

  // Running popcount of the busy vector
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy_count <= '0;
    end else begin
      case ({cnt_inc, cnt_dec})
        2'b10:   busy_count <= busy_count + 1'b1;
        2'b01:   busy_count <= busy_count - 1'b1;
        default: busy_count <= busy_count;
      endcase
    end
  end

  // Read port 1: x0 and INIT read as zero, optional same-cycle forwarding
  always_comb begin
    read_data1 = '0;
    read_busy1 = 1'b0;
    if (run && read_reg_num1 != '0) begin
      if (BYPASS != 0 && regwrite && write_reg == read_reg_num1) begin
        read_data1 = write_data;
      end else begin
        read_data1 = mem[read_reg_num1];
        read_busy1 = busy[read_reg_num1];
      end
    end
  end

  // Read port 2: same behaviour as port 1
  always_comb begin
    read_data2 = '0;
    read_busy2 = 1'b0;
    if (run && read_reg_num2 != '0) begin
      if (BYPASS != 0 && regwrite && write_reg == read_reg_num2) begin
        read_data2 = write_data;
      end else begin
        read_data2 = mem[read_reg_num2];
        read_busy2 = busy[read_reg_num2];
      end
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed self-checking bench for reg_file_sb (bypass and non-bypass copies).
module tb_reg_file_sb;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [4:0]  read_reg_num1 = '0;
  logic [4:0]  read_reg_num2 = '0;
  logic        regwrite = 1'b0;
  logic [4:0]  write_reg = '0;
  logic [31:0] write_data = '0;
  logic        claim_en = 1'b0;
  logic [4:0]  claim_reg = '0;

  logic        ready, read_busy1, read_busy2;
  logic [31:0] read_data1, read_data2;
  logic [5:0]  busy_count;

  logic        nb_ready, nb_busy1, nb_busy2;
  logic [31:0] nb_data1, nb_data2;
  logic [5:0]  nb_count;

  int n_cmp = 0;
  int n_err = 0;

  reg_file_sb #(.DATA_W(32), .ADDR_W(5), .BYPASS(1), .INIT_MODE(1)) dut (
    .clock(clock), .reset(reset), .ready(ready),
    .read_reg_num1(read_reg_num1), .read_data1(read_data1), .read_busy1(read_busy1),
    .read_reg_num2(read_reg_num2), .read_data2(read_data2), .read_busy2(read_busy2),
    .regwrite(regwrite), .write_reg(write_reg), .write_data(write_data),
    .claim_en(claim_en), .claim_reg(claim_reg), .busy_count(busy_count)
  );

  reg_file_sb #(.DATA_W(32), .ADDR_W(5), .BYPASS(0), .INIT_MODE(1)) dut_nb (
    .clock(clock), .reset(reset), .ready(nb_ready),
    .read_reg_num1(read_reg_num1), .read_data1(nb_data1), .read_busy1(nb_busy1),
    .read_reg_num2(read_reg_num2), .read_data2(nb_data2), .read_busy2(nb_busy2),
    .regwrite(regwrite), .write_reg(write_reg), .write_data(write_data),
    .claim_en(claim_en), .claim_reg(claim_reg), .busy_count(nb_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // advance one rising edge and settle away from it
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // reset state
    #2;
    chk("rst_ready", ready, 1'b0);
    chk("rst_count", busy_count, 6'd0);
    #20;                       // release mid-cycle, before edge at t=25
    reset = 1'b1;
    read_reg_num1 = 5'd7;
    #1;
    chk("init_data_zero", read_data1, 32'd0);

    // init sweep: ready low for edges 1..31, high at edge 32
    for (int i = 1; i <= 31; i++) begin
      tick();
      chk($sformatf("init_ready_e%0d", i), ready, 1'b0);
    end
    tick();
    chk("init_ready_e32", ready, 1'b1);
    chk("nb_ready_e32", nb_ready, 1'b1);

    // plan 1: init values
    read_reg_num1 = 5'd7;
    read_reg_num2 = 5'd0;
    #1;
    chk("rd_r7", read_data1, 32'h7);
    chk("rd_r0", read_data2, 32'h0);
    chk("count0", busy_count, 6'd0);

    // plan 2: bypass vs no bypass
    regwrite = 1'b1; write_reg = 5'd5; write_data = 32'hDEADBEEF;
    read_reg_num1 = 5'd5;
    #1;
    chk("byp_same_cycle", read_data1, 32'hDEADBEEF);
    chk("nobyp_same_cycle", nb_data1, 32'h5);
    tick();
    regwrite = 1'b0;
    #1;
    chk("byp_next", read_data1, 32'hDEADBEEF);
    chk("nobyp_next", nb_data1, 32'hDEADBEEF);

    // plan 3: register 0 write and claim are discarded
    regwrite = 1'b1; write_reg = 5'd0; write_data = 32'hFFFFFFFF;
    claim_en = 1'b1; claim_reg = 5'd0;
    read_reg_num1 = 5'd0; read_reg_num2 = 5'd0;
    #1;
    chk("r0_same_data", read_data1, 32'h0);
    chk("r0_same_busy", read_busy1, 1'b0);
    tick();
    regwrite = 1'b0; claim_en = 1'b0;
    #1;
    chk("r0_after_data", read_data2, 32'h0);
    chk("r0_after_busy", read_busy2, 1'b0);
    chk("r0_after_count", busy_count, 6'd0);

    // plan 4: claims, write clear, same-register claim+write
    claim_en = 1'b1; claim_reg = 5'd3;
    tick();
    claim_reg = 5'd4;
    tick();
    claim_en = 1'b0;
    read_reg_num1 = 5'd3; read_reg_num2 = 5'd4;
    #1;
    chk("claim_count2", busy_count, 6'd2);
    chk("claim_busy3", read_busy1, 1'b1);
    chk("claim_busy4", read_busy2, 1'b1);
    regwrite = 1'b1; write_reg = 5'd3; write_data = 32'h33;
    tick();
    regwrite = 1'b0;
    #1;
    chk("wr3_count1", busy_count, 6'd1);
    chk("wr3_busy", read_busy1, 1'b0);
    chk("wr3_data", read_data1, 32'h33);
    regwrite = 1'b1; write_reg = 5'd4; write_data = 32'h44;
    claim_en = 1'b1; claim_reg = 5'd4;
    tick();
    regwrite = 1'b0; claim_en = 1'b0;
    #1;
    chk("cw4_busy", read_busy2, 1'b1);
    chk("cw4_count", busy_count, 6'd1);
    chk("cw4_data", read_data2, 32'h44);

    // plan 5: claim+write of clear register 6 with read of 6
    regwrite = 1'b1; write_reg = 5'd6; write_data = 32'h66;
    claim_en = 1'b1; claim_reg = 5'd6;
    read_reg_num1 = 5'd6;
    #1;
    chk("cw6_same_busy", read_busy1, 1'b0);
    chk("cw6_same_data", read_data1, 32'h66);
    chk("cw6_nb_data", nb_data1, 32'h6);
    tick();
    regwrite = 1'b0; claim_en = 1'b0;
    #1;
    chk("cw6_next_busy", read_busy1, 1'b1);
    chk("cw6_next_data", read_data1, 32'h66);
    chk("cw6_count", busy_count, 6'd2);
    read_reg_num2 = 5'd5;
    #1;
    chk("pre_rst_r5", read_data2, 32'hDEADBEEF);

    // plan 6: asynchronous reset mid-cycle
    read_reg_num2 = 5'd4;
    #1;
    reset = 1'b0;
    #1;
    chk("arst_ready", ready, 1'b0);
    chk("arst_count", busy_count, 6'd0);
    chk("arst_busy1", read_busy1, 1'b0);
    chk("arst_busy2", read_busy2, 1'b0);
    #1;
    reset = 1'b1;
    regwrite = 1'b1; write_reg = 5'd5; write_data = 32'h12345678;
    claim_en = 1'b1; claim_reg = 5'd7;
    for (int i = 1; i <= 31; i++) begin
      tick();
      chk($sformatf("reinit_ready_e%0d", i), ready, 1'b0);
    end
    tick();
    regwrite = 1'b0; claim_en = 1'b0;
    chk("reinit_ready_e32", ready, 1'b1);
    read_reg_num1 = 5'd5; read_reg_num2 = 5'd7;
    #1;
    chk("reinit_r5", read_data1, 32'h5);
    chk("reinit_busy7", read_busy2, 1'b0);
    chk("reinit_count", busy_count, 6'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
